// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC/fetch FSM feeding WAY icache slots per cycle into inst_buff
//
// fetch_out packs WAY packets of 97 bits each, slot i at [i*97 +: 97]:
//   [96] valid, [95:64] inst, [63:32] PC, [31:0] NPC.

`ifndef WAY
`define WAY 2
`endif
`ifndef WAY_CNT_LEN
`define WAY_CNT_LEN 2
`endif

module fetch_stage #(
    parameter int          WAY      = `WAY,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    fetch_flush,
    input  logic [31:0]             fetch_target_pc,
    output logic [31:0]             icache_req_pc,
    input  logic [WAY-1:0]          icache_hit,
    input  logic [WAY*32-1:0]       icache_data,
    output logic                    icache_miss_req,
    input  logic                    icache_fill_done,
    output logic [WAY*97-1:0]       fetch_out,
    input  logic [`WAY_CNT_LEN-1:0] inst_buff_num_fetched,
    output logic [1:0]              fetch_state
);

    localparam logic [31:0] WFI_INST = 32'h10500073;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        MISS_REQ  = 2'd1,
        MISS_WAIT = 2'd2,
        HALTED    = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        ignore_fill_q, ignore_fill_d;

    logic [WAY-1:0]          slot_valid;
    logic [WAY-1:0]          slot_wfi;
    logic [`WAY_CNT_LEN-1:0] valid_cnt;
    logic [`WAY_CNT_LEN-1:0] num_acc;
    logic                    wfi_taken;
    logic                    chain;

    assign icache_req_pc = pc_q;
    assign fetch_state   = state_q;
    // Depends only on registered state and control inputs, never on hit/data.
    // A flush in MISS_REQ suppresses the pulse so no orphan fill is ever requested.
    assign icache_miss_req = (state_q == MISS_REQ) && !ignore_fill_q && !reset && !fetch_flush;

    // Slot validity: contiguous hit prefix, cut after the first WFI, none under flush/reset.
    always_comb begin
        slot_valid = '0;
        slot_wfi   = '0;
        valid_cnt  = '0;
        fetch_out  = '0;
        chain      = (state_q == RUN) && !fetch_flush && !reset;
        for (int i = 0; i < WAY; i++) begin
            slot_wfi[i]   = (icache_data[i*32 +: 32] == WFI_INST);
            slot_valid[i] = chain && icache_hit[i];
            chain         = slot_valid[i] && !slot_wfi[i];
            if (slot_valid[i]) begin
                valid_cnt = valid_cnt + 1'b1;
                fetch_out[i*97 +: 97] = {1'b1, icache_data[i*32 +: 32],
                                         pc_q + 32'(4 * i), pc_q + 32'(4 * (i + 1))};
            end
        end
    end

    // Clamp the accepted count to the valid prefix and detect an accepted WFI.
    always_comb begin
        num_acc   = (inst_buff_num_fetched > valid_cnt) ? valid_cnt : inst_buff_num_fetched;
        wfi_taken = 1'b0;
        for (int i = 0; i < WAY; i++) begin
            if (slot_valid[i] && slot_wfi[i] && (i < int'(num_acc))) begin
                wfi_taken = 1'b1;
            end
        end
    end

    // Next PC, FSM state and stale-fill filter.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        ignore_fill_d = ignore_fill_q;

        if (icache_fill_done && ignore_fill_q) begin
            ignore_fill_d = 1'b0;
        end else if (fetch_flush && (state_q == MISS_WAIT) && !icache_fill_done) begin
            ignore_fill_d = 1'b1;
        end

        if (fetch_flush) begin
            state_d = RUN;
            pc_d    = fetch_target_pc;
        end else begin
            case (state_q)
                RUN: begin
                    if (!icache_hit[0]) begin
                        state_d = MISS_REQ;
                    end else begin
                        // A WFI ends the valid prefix, so when it is accepted it is the
                        // last accepted slot and PC + 4*num is exactly its NPC.
                        pc_d = pc_q + (32'(num_acc) << 2);
                        if (wfi_taken) begin
                            state_d = HALTED;
                        end
                    end
                end
                MISS_REQ: begin
                    if (!ignore_fill_q) begin
                        state_d = MISS_WAIT;
                    end
                end
                MISS_WAIT: begin
                    if (icache_fill_done && !ignore_fill_q) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = HALTED;
                end
            endcase
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= RUN;
            pc_q          <= RESET_PC;
            ignore_fill_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            ignore_fill_q <= ignore_fill_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage with WAY=2

module tb_fetch_stage;

    localparam logic [31:0] WFI = 32'h10500073;
    localparam logic [31:0] D0  = 32'hAAAA0001;
    localparam logic [31:0] D1  = 32'hBBBB0002;

    typedef logic [96:0] pkt_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        fetch_flush;
    logic [31:0] fetch_target_pc;
    logic [31:0] icache_req_pc;
    logic [1:0]  icache_hit;
    logic [63:0] icache_data;
    logic        icache_miss_req;
    logic        icache_fill_done;
    logic [193:0] fetch_out;
    logic [1:0]  inst_buff_num_fetched;
    logic [1:0]  fetch_state;

    pkt_t        exp_pkts[$];
    logic [31:0] exp_miss[$];
    int          checks = 0;
    int          passes = 0;

    fetch_stage #(.WAY(2), .RESET_PC(32'h0)) dut (
        .clock                 (clock),
        .reset                 (reset),
        .fetch_flush           (fetch_flush),
        .fetch_target_pc       (fetch_target_pc),
        .icache_req_pc         (icache_req_pc),
        .icache_hit            (icache_hit),
        .icache_data           (icache_data),
        .icache_miss_req       (icache_miss_req),
        .icache_fill_done      (icache_fill_done),
        .fetch_out             (fetch_out),
        .inst_buff_num_fetched (inst_buff_num_fetched),
        .fetch_state           (fetch_state)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    function automatic pkt_t pk(input logic [31:0] pc, input logic [31:0] inst);
        return {1'b1, inst, pc, pc + 32'd4};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string n, input logic [1:0] st, input logic [31:0] pc);
        check({n, "_state"}, 128'(fetch_state), 128'(st));
        check({n, "_pc"}, 128'(icache_req_pc), 128'(pc));
    endtask

    // Monitor: consume expected packets / miss pulses whenever the DUT presents them.
    always @(negedge clock) begin
        pkt_t p;
        for (int i = 0; i < 2; i++) begin
            p = fetch_out[i*97 +: 97];
            if (p[96]) begin
                if (exp_pkts.size() == 0) check("unexpected_pkt", 128'(p), 128'(0));
                else check("pkt", 128'(p), 128'(exp_pkts.pop_front()));
            end else begin
                check("idle_slot_zero", 128'(p), 128'(0));
            end
        end
        if (icache_miss_req) begin
            if (exp_miss.size() == 0) check("unexpected_miss_req", 128'(icache_req_pc), 128'hDEAD);
            else check("miss_req_pc", 128'(icache_req_pc), 128'(exp_miss.pop_front()));
        end
    end

    initial begin
        reset = 1'b1; fetch_flush = 1'b0; fetch_target_pc = '0;
        icache_hit = 2'b11; icache_data = {D1, D0};
        inst_buff_num_fetched = 2'd2; icache_fill_done = 1'b0;
        step(); step();
        chk("reset", 2'd0, 32'h0);
        reset = 1'b0;

        exp_pkts.push_back(pk(32'h0, D0)); exp_pkts.push_back(pk(32'h4, D1));
        step(); chk("seq1", 2'd0, 32'h8);
        exp_pkts.push_back(pk(32'h8, D0)); exp_pkts.push_back(pk(32'hC, D1));
        step(); chk("seq2", 2'd0, 32'h10);

        fetch_flush = 1'b1; fetch_target_pc = 32'h40;
        step(); fetch_flush = 1'b0; chk("flush_all_hit", 2'd0, 32'h40);

        icache_hit = 2'b01; inst_buff_num_fetched = 2'd1;
        exp_pkts.push_back(pk(32'h40, D0));
        step(); chk("partial_hit", 2'd0, 32'h44);
        inst_buff_num_fetched = 2'd2;
        exp_pkts.push_back(pk(32'h44, D0));
        step(); chk("clamp", 2'd0, 32'h48);

        fetch_flush = 1'b1; fetch_target_pc = 32'h80; icache_hit = 2'b00; inst_buff_num_fetched = 2'd0;
        step(); fetch_flush = 1'b0; chk("redirect", 2'd0, 32'h80);
        inst_buff_num_fetched = 2'd2;
        step(); chk("miss_detect", 2'd1, 32'h80);
        exp_miss.push_back(32'h80);
        step(); chk("miss_wait", 2'd2, 32'h80);
        step(); chk("miss_hold", 2'd2, 32'h80);
        icache_fill_done = 1'b1;
        step(); icache_fill_done = 1'b0; chk("fill_done", 2'd0, 32'h80);

        icache_hit = 2'b11; inst_buff_num_fetched = 2'd0;
        exp_pkts.push_back(pk(32'h80, D0)); exp_pkts.push_back(pk(32'h84, D1));
        step(); chk("retry_no_accept", 2'd0, 32'h80);

        icache_hit = 2'b00;
        step(); chk("miss2", 2'd1, 32'h80);
        exp_miss.push_back(32'h80);
        step(); chk("miss2_wait", 2'd2, 32'h80);
        fetch_flush = 1'b1; fetch_target_pc = 32'h200;
        step(); fetch_flush = 1'b0; chk("flush_in_wait", 2'd0, 32'h200);
        step(); chk("miss3_req", 2'd1, 32'h200);
        step(); chk("miss3_blocked", 2'd1, 32'h200);
        icache_fill_done = 1'b1;
        step(); icache_fill_done = 1'b0; chk("stale_fill_drop", 2'd1, 32'h200);
        exp_miss.push_back(32'h200);
        step(); chk("miss3_wait", 2'd2, 32'h200);
        icache_fill_done = 1'b1;
        step(); icache_fill_done = 1'b0; chk("miss3_fill", 2'd0, 32'h200);

        icache_hit = 2'b11; icache_data = {D1, WFI}; inst_buff_num_fetched = 2'd1;
        exp_pkts.push_back(pk(32'h200, WFI));
        step(); chk("wfi_halt", 2'd3, 32'h204);
        inst_buff_num_fetched = 2'd2;
        step(); chk("halted_hold", 2'd3, 32'h204);
        fetch_flush = 1'b1; fetch_target_pc = 32'h10;
        step(); fetch_flush = 1'b0; chk("wake", 2'd0, 32'h10);

        icache_data = {WFI, D0}; inst_buff_num_fetched = 2'd1;
        exp_pkts.push_back(pk(32'h10, D0)); exp_pkts.push_back(pk(32'h14, WFI));
        step(); chk("wfi_not_taken", 2'd0, 32'h14);
        inst_buff_num_fetched = 2'd2;
        exp_pkts.push_back(pk(32'h14, D0)); exp_pkts.push_back(pk(32'h18, WFI));
        step(); chk("wfi_slot1_halt", 2'd3, 32'h1C);

        fetch_flush = 1'b1; fetch_target_pc = 32'h30; icache_hit = 2'b00; inst_buff_num_fetched = 2'd0;
        step(); fetch_flush = 1'b0; chk("wake2", 2'd0, 32'h30);
        step(); chk("miss4", 2'd1, 32'h30);
        exp_miss.push_back(32'h30);
        step(); chk("miss4_wait", 2'd2, 32'h30);
        fetch_flush = 1'b1; fetch_target_pc = 32'h40; icache_fill_done = 1'b1;
        step(); fetch_flush = 1'b0; icache_fill_done = 1'b0; chk("flush_fill_same", 2'd0, 32'h40);
        exp_miss.push_back(32'h40);
        step(); chk("miss5_req", 2'd1, 32'h40);
        step(); chk("miss5_wait", 2'd2, 32'h40);

        reset = 1'b1;
        step(); reset = 1'b0; chk("reset_mid_miss", 2'd0, 32'h0);
        icache_hit = 2'b11; icache_fill_done = 1'b1;
        exp_pkts.push_back(pk(32'h0, D0)); exp_pkts.push_back(pk(32'h4, WFI));
        step(); icache_fill_done = 1'b0; chk("stray_fill", 2'd0, 32'h0);

        fetch_flush = 1'b1; fetch_target_pc = 32'hFFFF_FFF8;
        step(); fetch_flush = 1'b0; chk("flush_high", 2'd0, 32'hFFFF_FFF8);
        icache_data = {D1, D0}; inst_buff_num_fetched = 2'd2;
        exp_pkts.push_back(pk(32'hFFFF_FFF8, D0)); exp_pkts.push_back(pk(32'hFFFF_FFFC, D1));
        step(); chk("wrap", 2'd0, 32'h0);

        check("pkt_queue_drained", 128'(exp_pkts.size()), 128'(0));
        check("miss_queue_drained", 128'(exp_miss.size()), 128'(0));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter WAY, default `WAY, sets the number of fetch slots per cycle.
REQ-002 Parameter RESET_PC, default 32'h0, sets the PC loaded at reset.
REQ-003 clock  in  1  clock; all state updates on posedge clock.
REQ-004 reset  in  1  reset, synchronous, active-high.
REQ-005 fetch_flush  in  1  redirect from ROB; same signal that flushes inst_buff.
REQ-006 fetch_target_pc  in  32  redirect PC, valid when fetch_flush=1.
REQ-007 icache_req_pc  out  32  address of fetch slot 0 (current PC).
REQ-008 icache_hit  in  WAY  per-slot hit for addresses icache_req_pc+4*i.
REQ-009 icache_data  in  WAY x 32  per-slot instruction word.
REQ-010 icache_miss_req  out  1  one-cycle pulse requesting a line fill for icache_req_pc.
REQ-011 icache_fill_done  in  1  one-cycle pulse: the requested fill is complete.
REQ-012 fetch_out  out  fetch_packet_t [WAY]  packets to inst_buff: valid, inst, PC, NPC.
REQ-013 inst_buff_num_fetched  in  `WAY_CNT_LEN  count of this cycle's packets accepted by inst_buff, same cycle.
REQ-014 fetch_state  out  2  current FSM state, for debug and verification.

Function
REQ-015 The block SHALL hold a 32-bit PC register and a 2-bit FSM with states RUN=0, MISS_REQ=1, MISS_WAIT=2, HALTED=3.
REQ-016 icache_req_pc SHALL equal PC in every state.
REQ-017 In RUN, slot i SHALL be valid iff icache_hit[0..i] are all 1, no earlier slot i' < i holds a WFI instruction (32'h10500073), and fetch_flush=0.
REQ-018 For each valid slot i: inst=icache_data[i], PC=PC+4*i, NPC=PC+4*(i+1); invalid slots SHALL be all-zero.
REQ-019 A WFI in slot i SHALL still be emitted as valid; only slots after it are suppressed.
REQ-020 In MISS_REQ, MISS_WAIT and HALTED, all fetch_out entries SHALL be all-zero.
REQ-021 Accepted packets form a prefix of the valid slots; the block SHALL treat inst_buff_num_fetched > (number of valid slots) as a protocol error and clamp to the valid count.
REQ-022 RUN, no flush: PC_next = PC + 4*num, with num = inst_buff_num_fetched after clamping; arithmetic is modulo 2^32.
REQ-023 RUN, icache_hit[0]=0, no flush: PC SHALL hold and the state SHALL become MISS_REQ.
REQ-024 MISS_REQ SHALL assert icache_miss_req for exactly one cycle and then go to MISS_WAIT.
REQ-025 MISS_WAIT SHALL hold until icache_fill_done=1, then return to RUN; the fetch retries at the same PC.
REQ-026 RUN: if the accepted prefix includes a WFI slot, PC_next SHALL be the NPC of that slot and the state SHALL become HALTED.
REQ-027 HALTED SHALL hold PC and issue no requests until fetch_flush.
REQ-028 fetch_flush=1 in any state SHALL set PC_next=fetch_target_pc and state=RUN, overriding REQ-022 through REQ-027.
REQ-029 A flush during MISS_WAIT SHALL set an ignore_fill flag; the next icache_fill_done is then dropped with no state effect, and the flag clears on that pulse or on reset.
REQ-030 fetch_flush and icache_fill_done in the same cycle SHALL clear the pending wait; ignore_fill SHALL NOT be set.
REQ-031 icache_miss_req SHALL NOT assert while ignore_fill=1; the state SHALL wait in MISS_REQ until the flag clears.
REQ-032 No combinational path SHALL exist from icache_hit or icache_data to icache_miss_req.

Reset
REQ-033 On reset: PC=RESET_PC, state=RUN, ignore_fill=0.
REQ-034 Reset SHALL take priority over fetch_flush and fill_done.
REQ-035 During the reset cycle, fetch_out SHALL be all-zero and icache_miss_req=0.
REQ-036 Reset mid-miss SHALL abandon the wait; a later stray fill_done SHALL be ignored (state RUN).

Verification
REQ-037 WAY=2, reset, all hits, num=2 every cycle -> PC sequence 0,8,16; slot1 PC=4, NPC=8.
REQ-038 PC=0x40, hit=2'b01, num=1 -> one valid packet (PC 0x40), PC_next=0x44.
REQ-039 PC=0x80, hit[0]=0 -> state MISS_REQ; one miss_req pulse; MISS_WAIT; fill_done -> RUN at 0x80.
REQ-040 MISS_WAIT, flush to 0x200 -> RUN at 0x200; the next fill_done is ignored; a subsequent miss issues miss_req only after that drop.
REQ-041 Slot0=WFI, num=1 -> HALTED, PC=PC+4, outputs zero; flush to 0x10 -> RUN at 0x10.
REQ-042 Flush concurrent with all hits and num=2 -> all slots invalid that cycle, PC_next=fetch_target_pc.
